// File: rtl/fake_n64_controller_rx.sv
// Controller-side Joybus receiver: decodes console command frames (cmd, addr,
// WRITE payload bytes) and toggles tx_handoff once per correctly stopped frame.
module fake_n64_controller_rx #(
   parameter int LEVEL_WIDTH  = 2,
   parameter int IDLE_TIMEOUT = 16 * LEVEL_WIDTH  // four bit periods
) (
   input  logic        sample_clk,
   input  logic        reset_n,
   input  logic        cur_operation,
   input  logic        data_rx,
   output logic [7:0]  cmd,
   output logic [15:0] addr,
   output logic [7:0]  byte_out,
   output logic        byte_valid,
   output logic        tx_handoff,
   output logic        frame_err
);

   typedef enum logic [2:0] {IDLE, WAIT_FALL, SAMPLE, WAIT_RISE, CHECK_STOP} state_t;

   localparam int LVL_W = $clog2(2 * LEVEL_WIDTH) + 1;
   localparam int TO_W  = $clog2(IDLE_TIMEOUT + 1);
   localparam logic [LVL_W-1:0] SAMPLE_AT  = LVL_W'(2 * LEVEL_WIDTH - 1);
   localparam logic [TO_W-1:0]  TIMEOUT_AT = TO_W'(IDLE_TIMEOUT);

   state_t           state, state_nxt;
   logic             meta_q, sync_q, prev_q;
   logic [LVL_W-1:0] lvl_cnt;
   logic [TO_W-1:0]  idle_cnt;
   logic [8:0]       bit_cnt, exp_len, bit_nxt;
   logic [7:0]       shift_q, shift_nxt;
   logic             fell, timeout, sample_pt;
   logic             start_bit, do_sample, stop_ok, abort_err;

   assign fell      = prev_q & ~sync_q;
   assign timeout   = (idle_cnt == TIMEOUT_AT) && (bit_cnt != 9'd0);
   assign sample_pt = (lvl_cnt == SAMPLE_AT);
   assign shift_nxt = {shift_q[6:0], sync_q};
   assign bit_nxt   = bit_cnt + 9'd1;

   // Synchronizer plus one extra stage for edge detection; idle_cnt measures
   // how long the synchronized line has held its level.
   always_ff @(posedge sample_clk or negedge reset_n) begin
      if (!reset_n) begin
         meta_q   <= 1'b1;
         sync_q   <= 1'b1;
         prev_q   <= 1'b1;
         idle_cnt <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         meta_q <= data_rx;
         sync_q <= meta_q;
         prev_q <= sync_q;
         if (sync_q != prev_q)
            idle_cnt <= '0;
         else if (idle_cnt != TIMEOUT_AT)
            idle_cnt <= idle_cnt + TO_W'(1);
      end
   end

   always_ff @(posedge sample_clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no latches.
      state_nxt = state;
      start_bit = 1'b0;
      do_sample = 1'b0;
      stop_ok   = 1'b0;
      abort_err = 1'b0;
      if (cur_operation) begin
         state_nxt = IDLE;
      end else if (state != IDLE && timeout) begin
         abort_err = 1'b1;
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:      state_nxt = WAIT_FALL;
            WAIT_FALL: if (fell) begin
               start_bit = 1'b1;
               state_nxt = (bit_cnt == exp_len) ? CHECK_STOP : SAMPLE;
            end
            SAMPLE:    if (sample_pt) begin
               do_sample = 1'b1;
               state_nxt = WAIT_RISE;
            end
            WAIT_RISE: if (sync_q) state_nxt = WAIT_FALL;
            CHECK_STOP: if (sample_pt) begin
               state_nxt = IDLE;
               if (sync_q) stop_ok   = 1'b1;
               else        abort_err = 1'b1;
            end
            default:   state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge sample_clk or negedge reset_n) begin
      if (!reset_n) begin
         lvl_cnt    <= '0;
         bit_cnt    <= '0;
         exp_len    <= 9'd8;
         shift_q    <= '0;
         cmd        <= '0;
         addr       <= '0;
         byte_out   <= '0;
         byte_valid <= 1'b0;
         tx_handoff <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         byte_valid <= 1'b0;
         if (state == IDLE) begin
            bit_cnt <= '0;
            lvl_cnt <= '0;
            exp_len <= 9'd8;
         end else if (start_bit) begin
            lvl_cnt <= '0;
            if (bit_cnt == 9'd0) frame_err <= 1'b0;
         end else if (state == SAMPLE || state == CHECK_STOP) begin
            lvl_cnt <= lvl_cnt + LVL_W'(1);
         end

         if (do_sample) begin
            shift_q <= shift_nxt;
            bit_cnt <= bit_nxt;
            // Frame length is fixed by the command byte the moment it completes.
            if (bit_nxt == 9'd8) begin
               cmd     <= shift_nxt;
               exp_len <= (shift_nxt == 8'h03) ? 9'd280 :
                          (shift_nxt == 8'h02) ? 9'd24  : 9'd8;
            end
            if (exp_len != 9'd8 && bit_nxt == 9'd16) addr[15:8] <= shift_nxt;
            if (exp_len != 9'd8 && bit_nxt == 9'd24) addr[7:0]  <= shift_nxt;
            if (exp_len == 9'd280 && bit_nxt >= 9'd32 && bit_nxt[2:0] == 3'd0) begin
               byte_out   <= shift_nxt;
               byte_valid <= 1'b1;
            end
         end

         if (stop_ok)   tx_handoff <= ~tx_handoff;
         if (abort_err) frame_err  <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fake_n64_controller_rx.sv
// Randomized bench for fake_n64_controller_rx: frames are built as byte lists and
// the expected register/strobe results are derived from those bytes.
module tb_fake_n64_controller_rx;

   localparam int LW = 2;
   localparam int TO = 16 * LW;

   typedef enum {END_OK, END_BAD, END_HOLD, END_ABORT} end_e;

   logic        sample_clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        cur_operation = 1'b0;
   logic        data_rx = 1'b1;
   logic [7:0]  cmd;
   logic [15:0] addr;
   logic [7:0]  byte_out;
   logic        byte_valid;
   logic        tx_handoff;
   logic        frame_err;

   fake_n64_controller_rx #(.LEVEL_WIDTH(LW), .IDLE_TIMEOUT(TO)) dut (
      .sample_clk   (sample_clk),
      .reset_n      (reset_n),
      .cur_operation(cur_operation),
      .data_rx      (data_rx),
      .cmd          (cmd),
      .addr         (addr),
      .byte_out     (byte_out),
      .byte_valid   (byte_valid),
      .tx_handoff   (tx_handoff),
      .frame_err    (frame_err)
   );

   always #5 sample_clk = ~sample_clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Monitor: collects byte strobes and handoff toggles on the falling edge.
   logic [7:0] got_bytes[$];
   int         toggles = 0;
   int         clash = 0;
   logic       hand_prev = 1'b0;

   always @(negedge sample_clk) begin
      if (reset_n && byte_valid) got_bytes.push_back(byte_out);
      if (reset_n && tx_handoff !== hand_prev) begin
         toggles++;
         if (byte_valid) clash++;
      end
      hand_prev = tx_handoff;
   end

   // Reference model state.
   logic [7:0]  frame_q[$];
   logic [7:0]  exp_bytes[$];
   logic [7:0]  m_cmd = 8'h00;
   logic [15:0] m_addr = 16'h0000;
   logic        m_hand = 1'b0;
   logic        m_err = 1'b0;
   int          m_toggles = 0;

   task automatic cycles(input int n);
      repeat (n) @(posedge sample_clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      data_rx = 1'b0;
      cycles((b ? 1 : 3) * LW);
      data_rx = 1'b1;
      cycles((b ? 3 : 1) * LW);
   endtask

   task automatic send_bits(input int nbits);
      logic [7:0] cur;
      for (int i = 0; i < nbits; i++) begin
         cur = frame_q[i / 8];
         send_bit(cur[7 - (i % 8)]);
      end
   endtask

   task automatic model_frame(input int nbits, input end_e e);
      logic [7:0] c;
      if (nbits == 0) return;
      m_err = 1'b0;
      c = frame_q[0];
      if (nbits >= 8) m_cmd = c;
      if (nbits >= 8 && (c == 8'h02 || c == 8'h03)) begin
         if (nbits >= 16) m_addr[15:8] = frame_q[1];
         if (nbits >= 24) m_addr[7:0]  = frame_q[2];
      end
      if (nbits >= 8 && c == 8'h03)
         for (int i = 3; (i + 1) * 8 <= nbits; i++) exp_bytes.push_back(frame_q[i]);
      case (e)
         END_OK: begin
            m_hand = ~m_hand;
            m_toggles++;
         end
         END_BAD, END_HOLD: m_err = 1'b1;
         default: ;
      endcase
   endtask

   task automatic send_frame(input int nbits, input end_e e);
      send_bits(nbits);
      case (e)
         END_OK:   send_bit(1'b1);
         END_BAD:  send_bit(1'b0);
         END_HOLD: cycles(TO + 8);
         default: begin
            cur_operation = 1'b1;
            send_bit(1'b0);
            send_bit(1'b1);
            cycles(4);
            cur_operation = 1'b0;
         end
      endcase
      cycles(8);
      model_frame(nbits, e);
   endtask

   task automatic make_frame(input logic [7:0] c, input logic [15:0] a);
      frame_q.delete();
      frame_q.push_back(c);
      if (c == 8'h02 || c == 8'h03) begin
         frame_q.push_back(a[15:8]);
         frame_q.push_back(a[7:0]);
      end
      if (c == 8'h03)
         for (int i = 0; i < 32; i++) frame_q.push_back(8'($urandom_range(0, 255)));
   endtask

   task automatic verify(input string tag);
      check({tag, "_cmd"}, 32'(cmd), 32'(m_cmd));
      check({tag, "_addr"}, 32'(addr), 32'(m_addr));
      check({tag, "_frame_err"}, 32'(frame_err), 32'(m_err));
      check({tag, "_tx_handoff"}, 32'(tx_handoff), 32'(m_hand));
      check({tag, "_toggles"}, 32'(toggles), 32'(m_toggles));
      check({tag, "_nbytes"}, 32'(got_bytes.size()), 32'(exp_bytes.size()));
      for (int i = 0; i < exp_bytes.size() && i < got_bytes.size(); i++)
         check($sformatf("%s_byte%0d", tag, i), 32'(got_bytes[i]), 32'(exp_bytes[i]));
      got_bytes.delete();
      exp_bytes.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_cmd"}, 32'(cmd), 32'h0);
      check({tag, "_addr"}, 32'(addr), 32'h0);
      check({tag, "_byte_out"}, 32'(byte_out), 32'h0);
      check({tag, "_byte_valid"}, 32'(byte_valid), 32'h0);
      check({tag, "_tx_handoff"}, 32'(tx_handoff), 32'h0);
      check({tag, "_frame_err"}, 32'(frame_err), 32'h0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [7:0] c;
      cycles(3);
      check_reset_outputs("reset");
      reset_n = 1'b1;
      cycles(6);

      make_frame(8'h01, 16'h0);
      send_frame(8, END_OK);
      verify("cmd01");

      make_frame(8'h02, 16'h8001);
      send_frame(24, END_OK);
      verify("read");

      frame_q.delete();
      frame_q.push_back(8'h03);
      frame_q.push_back(8'hC0);
      frame_q.push_back(8'h1B);
      for (int i = 0; i < 32; i++) frame_q.push_back(8'(i));
      send_frame(280, END_OK);
      verify("write_seq");

      for (int n = 0; n < 6; n++) begin
         case ($urandom_range(0, 3))
            0:       c = 8'h02;
            1:       c = 8'h03;
            default: c = 8'($urandom_range(0, 255));
         endcase
         make_frame(c, 16'($urandom_range(0, 65535)));
         send_frame(frame_q.size() * 8, END_OK);
         verify($sformatf("rand%0d", n));
      end

      make_frame(8'h03, 16'($urandom_range(0, 65535)));
      send_frame(64, END_HOLD);
      verify("timeout");

      make_frame(8'hFF, 16'h0);
      send_frame(8, END_BAD);
      verify("bad_stop");

      make_frame(8'h00, 16'h0);
      send_frame(8, END_OK);
      verify("recover");

      make_frame(8'h02, 16'h5AA5);
      send_frame(12, END_ABORT);
      verify("op_abort");

      make_frame(8'h03, 16'h1234);
      send_frame(20, END_ABORT);
      verify("write_abort");

      make_frame(8'h03, 16'h4321);
      send_bits(40);
      reset_n = 1'b0;
      #1;
      check_reset_outputs("midframe_reset");
      data_rx = 1'b1;
      cycles(4);
      got_bytes.delete();
      exp_bytes.delete();
      toggles = 0;
      m_toggles = 0;
      m_cmd = 8'h00;
      m_addr = 16'h0000;
      m_hand = 1'b0;
      m_err = 1'b0;
      reset_n = 1'b1;
      cycles(4);

      make_frame(8'h00, 16'h0);
      send_frame(8, END_OK);
      verify("post_reset");

      check("no_strobe_handoff_clash", 32'(clash), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fake_n64_controller_rx.md
FAKE_N64_CONTROLLER_RX -- requirements
Module: fake_n64_controller_rx

Interface
REQ-001 SHALL have parameter LEVEL_WIDTH, default 2: sample_clk cycles per Joybus level; BIT_WIDTH = 4*LEVEL_WIDTH.
REQ-002 SHALL have parameter IDLE_TIMEOUT, default 4*BIT_WIDTH: sample_clk cycles of constant line level that abort a frame in progress.
REQ-003 SHALL have port sample_clk  input  1  sole clock; all state updates on posedge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port cur_operation  input  1  0 = Rx phase (receiver active), 1 = Tx phase (receiver held idle).
REQ-006 SHALL have port data_rx  input  1  raw Joybus line from console, asynchronous, idle high.
REQ-007 SHALL have port cmd  output  8  last received command byte.
REQ-008 SHALL have port addr  output  16  address field of last READ (0x02) or WRITE (0x03) frame.
REQ-009 SHALL have port byte_out  output  8  WRITE payload byte, MSB received first.
REQ-010 SHALL have port byte_valid  output  1  one-cycle strobe qualifying byte_out.
REQ-011 SHALL have port tx_handoff  output  1  toggles once per correctly terminated frame.
REQ-012 SHALL have port frame_err  output  1  set on aborted or malformed frame; cleared at next frame start.

Function
REQ-013 SHALL pass data_rx through a 2-flop synchronizer; all decoding uses the synchronized value, adding 2 cycles of latency.
REQ-014 SHALL implement states IDLE, WAIT_FALL, SAMPLE, WAIT_RISE, CHECK_STOP.
REQ-015 While cur_operation=1, SHALL force IDLE, hold outputs, and ignore data_rx.
REQ-016 IDLE -> WAIT_FALL when cur_operation=0; resets the bit counter (9 bits) and the level counter.
REQ-017 WAIT_FALL: a synchronized high-to-low transition starts a bit; go to SAMPLE and clear frame_err if bit counter = 0.
REQ-018 SAMPLE: SHALL sample the line 2*LEVEL_WIDTH cycles after the falling edge; low = logic 0, high = logic 1.
REQ-019 SHALL shift the sampled bit MSB-first into an 8-bit shift register, increment the bit counter, and go to WAIT_RISE.
REQ-020 WAIT_RISE: waits for the line to go high, then returns to WAIT_FALL; if the line is already high, returns immediately.
REQ-021 Expected data length SHALL be fixed once bit 8 completes: cmd 0x03 = 280 bits, 0x02 = 24 bits, any other value = 8 bits.
REQ-022 On bit 8, SHALL load cmd from the shift register.
REQ-023 On bits 16 and 24 of READ/WRITE frames, SHALL load addr[15:8] and addr[7:0] respectively.
REQ-024 For WRITE, on bits 32, 40, ..., 280, SHALL drive byte_out and pulse byte_valid for exactly one cycle (32 strobes per frame).
REQ-025 After the expected bit count, the next falling edge SHALL enter CHECK_STOP, which samples at 2*LEVEL_WIDTH cycles.
REQ-026 CHECK_STOP: a high sample is a valid stop; SHALL toggle tx_handoff once and go to IDLE.
REQ-027 CHECK_STOP: a low sample SHALL set frame_err, suppress the handoff, and go to IDLE.
REQ-028 In any non-IDLE state, if the line level stays constant for IDLE_TIMEOUT cycles with bit counter > 0, SHALL set frame_err, suppress the handoff, and go to IDLE.
REQ-029 Timeout in WAIT_FALL with bit counter = 0 SHALL NOT set frame_err; the receiver keeps waiting.
REQ-030 cmd and addr SHALL remain stable from load until the next frame's corresponding bit; a partial frame SHALL NOT alter fields not yet reached.
REQ-031 If cur_operation goes to 1 mid-frame, SHALL abort silently to IDLE with no handoff and no frame_err change.
REQ-032 byte_valid and the tx_handoff toggle SHALL never coincide; the stop bit always follows the last byte strobe by at least BIT_WIDTH cycles.

Reset
REQ-033 Asserting reset_n low SHALL immediately force: state IDLE, synchronizer flops 1, cmd 0x00, addr 0x0000, byte_out 0x00, byte_valid 0, tx_handoff 0, frame_err 0, all counters 0.
REQ-034 Deassertion SHALL take effect on the next sample_clk posedge; a reset mid-frame discards the partial frame.

Verification
REQ-035 Send 0x01 (8 bits) + stop, LEVEL_WIDTH=2 -> cmd=0x01, tx_handoff toggles 0->1, frame_err=0, byte_valid never asserted.
REQ-036 Send 0x02, addr 0x8001, stop -> cmd=0x02, addr=0x8001, exactly one tx_handoff toggle.
REQ-037 Send 0x03, addr 0xC01B, payload bytes 0x00..0x1F, stop -> 32 byte_valid pulses with byte_out 0x00..0x1F in order, then one handoff toggle.
REQ-038 Send 0x03, addr, 5 bytes, then hold line high -> frame_err=1 after IDLE_TIMEOUT cycles, no handoff, cmd=0x03.
REQ-039 Send 0xFF with stop bit held low through the sample point -> frame_err=1, tx_handoff unchanged.
REQ-040 Assert reset_n low mid-WRITE with cur_operation toggled during the frame -> all outputs at reset values, next clean 0x00 frame decodes correctly.
